// File: rtl/temporizador_mmss_if.sv
// Command/preset/display bundle between the countdown timer and its controller.
// The slave side is the timer; the master side drives commands and reads the display.
interface temporizador_mmss_if;
    logic       carregar;
    logic       iniciar;
    logic       pausar;
    logic [3:0] ini_min_dez;
    logic [3:0] ini_min_uni;
    logic [3:0] ini_seg_dez;
    logic [3:0] ini_seg_uni;
    logic [3:0] min_dez;
    logic [3:0] min_uni;
    logic [3:0] seg_dez;
    logic [3:0] seg_uni;
    logic       rodando;
    logic       fim;
    logic [1:0] estado;

    modport master (
        output carregar, iniciar, pausar,
        output ini_min_dez, ini_min_uni, ini_seg_dez, ini_seg_uni,
        input  min_dez, min_uni, seg_dez, seg_uni,
        input  rodando, fim, estado
    );

    modport slave (
        input  carregar, iniciar, pausar,
        input  ini_min_dez, ini_min_uni, ini_seg_dez, ini_seg_uni,
        output min_dez, min_uni, seg_dez, seg_uni,
        output rodando, fim, estado
    );
endinterface

// File: rtl/temporizador_mmss.sv
// MM:SS BCD countdown timer (max 99:59) with a 1 s prescaler and a one-cycle end pulse.
// Digit index 0..3 = seg_uni, seg_dez, min_uni, min_dez.
module temporizador_mmss #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    temporizador_mmss_if.slave  bus
);
    localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    digit_q [4];
    logic [3:0]    digit_d [4];
    logic          fim_q, fim_d;
    logic          rodando_q, rodando_d;

    logic [3:0]    ini_digit  [4];
    logic [3:0]    load_digit [4];
    logic [3:0]    dec_digit  [4];
    logic [3:0]    borrow;
    logic          value_zero;
    logic          dec_zero;
    logic          tick;

    assign ini_digit[0] = bus.ini_seg_uni;
    assign ini_digit[1] = bus.ini_seg_dez;
    assign ini_digit[2] = bus.ini_min_uni;
    assign ini_digit[3] = bus.ini_min_dez;

    // Per-digit clamp and borrow-chain decrement; seconds tens tops out at 5.
    assign borrow[0] = 1'b1;
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        localparam logic [3:0] MAXV = (gi == 1) ? 4'd5 : 4'd9;

        assign load_digit[gi] = (ini_digit[gi] > MAXV) ? MAXV : ini_digit[gi];
        assign dec_digit[gi]  = !borrow[gi]            ? digit_q[gi] :
                                (digit_q[gi] == 4'd0)  ? MAXV        :
                                                         digit_q[gi] - 4'd1;
        if (gi < 3) begin : g_borrow
            assign borrow[gi+1] = borrow[gi] && (digit_q[gi] == 4'd0);
        end
    end

    assign value_zero = (digit_q[0] == 4'd0) && (digit_q[1] == 4'd0) &&
                        (digit_q[2] == 4'd0) && (digit_q[3] == 4'd0);
    assign dec_zero   = (dec_digit[0] == 4'd0) && (dec_digit[1] == 4'd0) &&
                        (dec_digit[2] == 4'd0) && (dec_digit[3] == 4'd0);
    assign tick       = (state_q == RUN) && (presc_q == PRESC_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            fim_q     <= 1'b0;
            rodando_q <= 1'b0;
            for (int i = 0; i < 4; i++) digit_q[i] <= 4'd0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            fim_q     <= fim_d;
            rodando_q <= rodando_d;
            for (int i = 0; i < 4; i++) digit_q[i] <= digit_d[i];
        end
    end

    // Load beats everything; pausar beats iniciar; reaching 00:00 beats pausar.
    always_comb begin
        state_d = state_q;
        if (bus.carregar) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.iniciar && !bus.pausar && !value_zero) state_d = RUN;
                RUN:     if (tick && dec_zero) state_d = DONE;
                         else if (bus.pausar)  state_d = PAUSE;
                PAUSE:   if (bus.iniciar && !bus.pausar) state_d = RUN;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // The prescaler only advances while staying in RUN; a pause edge freezes the partial second.
    always_comb begin
        presc_d = presc_q;
        fim_d   = 1'b0;
        for (int i = 0; i < 4; i++) digit_d[i] = digit_q[i];
        if (bus.carregar) begin
            presc_d = '0;
            for (int i = 0; i < 4; i++) digit_d[i] = load_digit[i];
        end else if (state_q == IDLE && state_d == RUN) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            if (tick) begin
                presc_d = '0;
                fim_d   = dec_zero;
                for (int i = 0; i < 4; i++) digit_d[i] = dec_digit[i];
            end else if (!bus.pausar) begin
                presc_d = presc_q + 1'b1;
            end
        end
        rodando_d = (state_d == RUN);
    end

    assign bus.seg_uni = digit_q[0];
    assign bus.seg_dez = digit_q[1];
    assign bus.min_uni = digit_q[2];
    assign bus.min_dez = digit_q[3];
    assign bus.estado  = state_q;
    assign bus.rodando = rodando_q;
    assign bus.fim     = fim_q;
endmodule

// File: tb/tb_temporizador_mmss.sv
// Directed bench for the MM:SS countdown timer: stimulus pushes expected snapshots, a monitor pops and compares.
module tb_temporizador_mmss;
    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic reset_n = 1'b1;

    temporizador_mmss_if bus ();

    temporizador_mmss #(.TICKS_PER_SEC(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 if (clk_en) clk = ~clk;

    typedef struct packed {
        logic [15:0] digits;
        logic [1:0]  estado;
        logic        rodando;
        logic        fim;
    } snap_t;

    snap_t exp_q [$];
    string name_q [$];
    int n_pushed = 0;
    int n_popped = 0;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_st(input string name, input logic [15:0] d,
                             input logic [1:0] st, input logic f);
        snap_t e;
        e.digits  = d;
        e.estado  = st;
        e.rodando = (st == 2'd1);
        e.fim     = f;
        exp_q.push_back(e);
        name_q.push_back(name);
        n_pushed++;
    endtask

    task automatic set_preset(input logic [15:0] d);
        bus.ini_min_dez = d[15:12];
        bus.ini_min_uni = d[11:8];
        bus.ini_seg_dez = d[7:4];
        bus.ini_seg_uni = d[3:0];
    endtask

    task automatic load(input logic [15:0] d);
        set_preset(d);
        bus.carregar = 1'b1;
        cyc(1);
        bus.carregar = 1'b0;
    endtask

    task automatic start();
        bus.iniciar = 1'b1;
        cyc(1);
        bus.iniciar = 1'b0;
    endtask

    // Monitor: compares every pushed expectation against the live outputs.
    initial begin
        forever begin
            snap_t e;
            snap_t a;
            string nm;
            wait (n_pushed != n_popped);
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_popped++;
            a = {bus.min_dez, bus.min_uni, bus.seg_dez, bus.seg_uni,
                 bus.estado, bus.rodando, bus.fim};
            n_checks++;
            if (a !== e) begin
                $display("FAIL %s: got %h:%h estado=%0d rodando=%b fim=%b, expected %h:%h estado=%0d rodando=%b fim=%b",
                         nm, a.digits[15:8], a.digits[7:0], a.estado, a.rodando, a.fim,
                         e.digits[15:8], e.digits[7:0], e.estado, e.rodando, e.fim);
            end else begin
                n_pass++;
                $display("ok   %s: %h:%h estado=%0d rodando=%b fim=%b",
                         nm, a.digits[15:8], a.digits[7:0], a.estado, a.rodando, a.fim);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus.carregar = 1'b0;
        bus.iniciar  = 1'b0;
        bus.pausar   = 1'b0;
        set_preset(16'h0000);

        // Reset with the clock stopped
        #2 reset_n = 1'b0;
        #2 expect_st("reset_no_clk", 16'h0000, 2'd0, 1'b0);
        #2 clk_en = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);

        // 01:00 -> 00:59 after 4 clks, 00:57 after 8 more
        load(16'h0100);
        expect_st("load_0100", 16'h0100, 2'd0, 1'b0);
        start();
        expect_st("run_entry", 16'h0100, 2'd1, 1'b0);
        cyc(3);
        expect_st("before_tick", 16'h0100, 2'd1, 1'b0);
        cyc(1);
        expect_st("first_tick", 16'h0059, 2'd1, 1'b0);
        cyc(8);
        expect_st("two_more_secs", 16'h0057, 2'd1, 1'b0);

        // Borrow through every digit
        load(16'h1000);
        start();
        cyc(4);
        expect_st("borrow_1000", 16'h0959, 2'd1, 1'b0);

        // 00:02 to DONE, fim pulse, DONE ignores commands
        load(16'h0002);
        expect_st("load_0002", 16'h0002, 2'd0, 1'b0);
        start();
        cyc(4);
        expect_st("one_left", 16'h0001, 2'd1, 1'b0);
        cyc(4);
        expect_st("reach_zero", 16'h0000, 2'd3, 1'b1);
        cyc(1);
        expect_st("fim_drops", 16'h0000, 2'd3, 1'b0);
        start();
        expect_st("done_ign_ini", 16'h0000, 2'd3, 1'b0);
        bus.pausar = 1'b1;
        cyc(1);
        bus.pausar = 1'b0;
        expect_st("done_ign_pau", 16'h0000, 2'd3, 1'b0);

        // Pause keeps the partial second
        load(16'h0005);
        start();
        cyc(2);
        expect_st("run_2clk", 16'h0005, 2'd1, 1'b0);
        bus.pausar = 1'b1;
        cyc(10);
        bus.pausar = 1'b0;
        expect_st("paused", 16'h0005, 2'd2, 1'b0);
        start();
        expect_st("resumed", 16'h0005, 2'd1, 1'b0);
        cyc(1);
        expect_st("resume_1clk", 16'h0005, 2'd1, 1'b0);
        cyc(1);
        expect_st("resume_2clk", 16'h0004, 2'd1, 1'b0);

        // pausar on a tick: decrement then PAUSE
        cyc(3);
        bus.pausar = 1'b1;
        cyc(1);
        bus.pausar = 1'b0;
        expect_st("pause_on_tick", 16'h0003, 2'd2, 1'b0);

        // carregar on a tick: load wins, no decrement
        start();
        cyc(3);
        expect_st("pre_tick_0003", 16'h0003, 2'd1, 1'b0);
        load(16'h0030);
        expect_st("load_on_tick", 16'h0030, 2'd0, 1'b0);

        // Clamping with simultaneous iniciar
        set_preset(16'hAF7C);
        bus.carregar = 1'b1;
        bus.iniciar  = 1'b1;
        cyc(1);
        bus.carregar = 1'b0;
        bus.iniciar  = 1'b0;
        expect_st("clamp_load", 16'h9959, 2'd0, 1'b0);

        // iniciar at 00:00 is ignored
        load(16'h0000);
        start();
        expect_st("start_at_zero", 16'h0000, 2'd0, 1'b0);
        cyc(4);
        expect_st("zero_stays", 16'h0000, 2'd0, 1'b0);

        // Asynchronous reset mid-RUN
        load(16'h0037);
        start();
        cyc(2);
        #1 reset_n = 1'b0;
        #1 expect_st("async_reset", 16'h0000, 2'd0, 1'b0);
        cyc(2);
        expect_st("reset_held", 16'h0000, 2'd0, 1'b0);
        reset_n = 1'b1;
        cyc(1);
        expect_st("after_release", 16'h0000, 2'd0, 1'b0);

        #1;
        if (n_popped != n_pushed) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d compared, expected %0d", n_popped, n_pushed);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
